// File: rtl/irq_ctrl.sv
// Vectored interrupt controller: rising-edge request capture, mask/global enable,
// lowest-index selection, PC redirect to vector and return via IRET (no nesting).
module irq_ctrl #(
  parameter int               WIDTH      = 8,
  parameter int               N_IRQ      = 4,
  parameter logic [WIDTH-1:0] VEC_BASE   = 8'hF0,
  parameter int               VEC_STRIDE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_IRQ-1:0] irq_in,
  input  logic             mask_ld,
  input  logic [N_IRQ-1:0] mask_data,
  input  logic             ei,
  input  logic             di,
  input  logic             iret,
  input  logic [WIDTH-1:0] pc_cur,
  output logic             irq_pc_ld,
  output logic [WIDTH-1:0] irq_pc_addr,
  output logic             squash,
  output logic             in_service,
  output logic [2:0]       irq_id,
  output logic [N_IRQ-1:0] pending
);

  typedef enum logic [1:0] {IDLE, TAKE, SERVICE} state_t;

  state_t             state_reg, state_next;
  logic [N_IRQ-1:0]   pending_reg, pending_next;
  logic [N_IRQ-1:0]   mask_reg;
  logic               gie_reg;
  logic [N_IRQ-1:0]   irq_prev_reg;
  logic [WIDTH-1:0]   saved_pc_reg;
  logic [2:0]         irq_id_reg;

  logic [N_IRQ-1:0]   event_vec;
  logic [N_IRQ-1:0]   eligible;
  logic [N_IRQ-1:0]   clear_vec;
  logic [2:0]         winner;
  logic               any_eligible;
  logic               ctrl_en;
  logic [WIDTH-1:0]   vector_addr;

  assign event_vec    = irq_in & ~irq_prev_reg;
  assign eligible     = pending_reg & mask_reg & {N_IRQ{gie_reg}};
  assign any_eligible = |eligible;
  // The squashed instruction in TAKE re-executes later, so its control inputs are dropped now.
  assign ctrl_en      = (state_reg != TAKE);
  assign vector_addr  = VEC_BASE + WIDTH'(irq_id_reg) * WIDTH'(VEC_STRIDE);

  generate
    for (genvar gi = 0; gi < N_IRQ; gi++) begin : g_clear
      assign clear_vec[gi] = (state_reg == TAKE) && (irq_id_reg == 3'(gi));
    end
  endgenerate

  // A fresh event beats the clear of the line being taken.
  assign pending_next = (pending_reg & ~clear_vec) | event_vec;
  assign pending      = pending_reg;

  always_comb begin
    winner = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (eligible[i]) winner = 3'(i);
    end
  end

  always_comb begin
    state_next  = state_reg;
    irq_pc_ld   = 1'b0;
    irq_pc_addr = '0;
    squash      = 1'b0;
    in_service  = 1'b0;
    irq_id      = '0;
    case (state_reg)
      IDLE: begin
        if (any_eligible) state_next = TAKE;
      end
      TAKE: begin
        irq_pc_ld   = 1'b1;
        irq_pc_addr = vector_addr;
        squash      = 1'b1;
        in_service  = 1'b1;
        irq_id      = irq_id_reg;
        state_next  = SERVICE;
      end
      SERVICE: begin
        in_service = 1'b1;
        irq_id     = irq_id_reg;
        if (iret) begin
          irq_pc_ld   = 1'b1;
          irq_pc_addr = saved_pc_reg;
          state_next  = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      pending_reg  <= '0;
      mask_reg     <= '0;
      gie_reg      <= 1'b0;
      irq_prev_reg <= '0;
      saved_pc_reg <= '0;
      irq_id_reg   <= '0;
    end else begin
      state_reg    <= state_next;
      pending_reg  <= pending_next;
      irq_prev_reg <= irq_in;
      if (ctrl_en && mask_ld) mask_reg <= mask_data;
      if (ctrl_en && di)      gie_reg  <= 1'b0;
      else if (ctrl_en && ei) gie_reg  <= 1'b1;
      if (state_reg == TAKE) saved_pc_reg <= pc_cur;
      if (state_reg == IDLE && any_eligible) irq_id_reg <= winner;
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Self-checking bench for irq_ctrl: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model of the interrupt rules.
module tb_irq_ctrl;
  localparam int WIDTH = 8;
  localparam int N     = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [N-1:0]     irq_in = '0;
  logic             mask_ld = 1'b0;
  logic [N-1:0]     mask_data = '0;
  logic             ei = 1'b0, di = 1'b0, iret = 1'b0;
  logic [WIDTH-1:0] pc_cur = 8'h12;
  logic             irq_pc_ld, squash, in_service;
  logic [WIDTH-1:0] irq_pc_addr;
  logic [2:0]       irq_id;
  logic [N-1:0]     pending;

  int checks = 0;
  int errors = 0;

  // behavioural model state
  logic [N-1:0]     m_pending, m_mask, m_prev;
  logic             m_gie, m_busy, m_take;
  int               m_id;
  logic [WIDTH-1:0] m_saved;

  irq_ctrl #(.WIDTH(WIDTH), .N_IRQ(N), .VEC_BASE(8'hF0), .VEC_STRIDE(4)) dut (
    .clk(clk), .rst(rst), .irq_in(irq_in), .mask_ld(mask_ld), .mask_data(mask_data),
    .ei(ei), .di(di), .iret(iret), .pc_cur(pc_cur), .irq_pc_ld(irq_pc_ld),
    .irq_pc_addr(irq_pc_addr), .squash(squash), .in_service(in_service),
    .irq_id(irq_id), .pending(pending)
  );

  always #5 clk = ~clk;

  wire [17:0] obs = {irq_pc_ld, irq_pc_addr, squash, in_service, irq_id, pending};

  function automatic logic [17:0] exp_vec();
    logic ld;
    int   addr;
    ld   = m_take || (m_busy && iret);
    addr = m_take ? (240 + m_id * 4) % 256 : (ld ? int'(m_saved) : 0);
    return {ld, 8'(addr), m_take, m_busy, (m_busy ? 3'(m_id) : 3'd0), m_pending};
  endfunction

  task automatic model_reset();
    m_pending = '0; m_mask = '0; m_prev = '0; m_gie = 0;
    m_busy = 0; m_take = 0; m_id = 0; m_saved = '0;
  endtask

  task automatic model_update();
    logic [N-1:0] ev, elig;
    ev = irq_in & ~m_prev;
    m_prev = irq_in;
    if (m_take) begin
      m_saved = pc_cur;
      m_pending[m_id] = 1'b0;
      m_take = 0;
    end else begin
      if (m_busy) begin
        if (iret) m_busy = 0;
      end else begin
        elig = m_pending & m_mask & {N{m_gie}};
        for (int i = N - 1; i >= 0; i--)
          if (elig[i]) begin m_id = i; m_busy = 1; m_take = 1; end
      end
      if (mask_ld) m_mask = mask_data;
      if (di) m_gie = 0; else if (ei) m_gie = 1;
    end
    m_pending = m_pending | ev;
  endtask

  task automatic step();
    if (rst) model_reset(); else model_update();
    @(posedge clk); #1;
  endtask

  task automatic drive(input logic [N-1:0] i_irq, input logic i_mld, input logic [N-1:0] i_md,
                       input logic i_ei, input logic i_di, input logic i_iret);
    irq_in = i_irq; mask_ld = i_mld; mask_data = i_md; ei = i_ei; di = i_di; iret = i_iret;
    #1;
  endtask

  task automatic finish_service();
    for (int k = 0; k < 10 && m_busy; k++) begin
      drive('0, 0, '0, 0, 0, m_busy && !m_take);
      step();
    end
    drive('0, 0, '0, 0, 0, 0);
  endtask

  task automatic test_reset();
    model_reset();
    drive('0, 0, '0, 0, 0, 1);
    checks++;
    if (obs !== 18'd0) begin errors++; $display("FAIL reset_outputs got=%h exp=0", obs); end
    step();
    drive(4'b0011, 1, 4'hF, 1, 0, 1);
    checks++;
    if (obs !== 18'd0) begin errors++; $display("FAIL reset_held got=%h exp=0", obs); end
    step();
    drive('0, 0, '0, 0, 0, 0);
    rst = 1'b0;
    step();
  endtask

  task automatic test_single();
    drive('0, 1, 4'hF, 1, 0, 0); step();
    drive(4'b0100, 0, '0, 0, 0, 0); step();
    drive('0, 0, '0, 0, 0, 0);
    checks++;
    if (pending !== 4'b0100 || squash !== 1'b0) begin
      errors++; $display("FAIL single_pending got=%b/%b exp=0100/0", pending, squash); end
    step();
    drive('0, 0, '0, 0, 0, 0);
    checks++;
    if ({irq_pc_ld, irq_pc_addr, squash, in_service, irq_id} !== {1'b1, 8'hF8, 1'b1, 1'b1, 3'd2}) begin
      errors++; $display("FAIL single_take got ld=%b addr=%h sq=%b id=%0d exp 1/f8/1/2",
                         irq_pc_ld, irq_pc_addr, squash, irq_id); end
    step();
    drive('0, 0, '0, 0, 0, 0);
    checks++;
    if (in_service !== 1'b1 || pending !== 4'b0000 || irq_pc_ld !== 1'b0) begin
      errors++; $display("FAIL single_service got=%b/%b/%b exp=1/0000/0", in_service, pending, irq_pc_ld); end
    step();
    drive('0, 0, '0, 0, 0, 1);
    checks++;
    if (irq_pc_ld !== 1'b1 || irq_pc_addr !== 8'h12 || squash !== 1'b0) begin
      errors++; $display("FAIL single_iret got=%b/%h/%b exp=1/12/0", irq_pc_ld, irq_pc_addr, squash); end
    step();
    drive('0, 0, '0, 0, 0, 0);
    checks++;
    if (in_service !== 1'b0 || irq_pc_ld !== 1'b0) begin
      errors++; $display("FAIL single_idle got=%b/%b exp=0/0", in_service, irq_pc_ld); end
    step();
  endtask

  task automatic test_priority();
    drive(4'b1010, 0, '0, 0, 0, 0); step();
    drive('0, 0, '0, 0, 0, 0); step();
    drive('0, 0, '0, 0, 0, 0);
    checks++;
    if (squash !== 1'b1 || irq_id !== 3'd1 || irq_pc_addr !== 8'hF4) begin
      errors++; $display("FAIL prio_first got=%b/%0d/%h exp=1/1/f4", squash, irq_id, irq_pc_addr); end
    step();
    drive('0, 0, '0, 0, 0, 1);
    checks++;
    if (irq_pc_ld !== 1'b1 || irq_pc_addr !== 8'h12) begin
      errors++; $display("FAIL prio_iret got=%b/%h exp=1/12", irq_pc_ld, irq_pc_addr); end
    step();
    drive('0, 0, '0, 0, 0, 0);
    checks++;
    if (in_service !== 1'b0 || squash !== 1'b0 || pending !== 4'b1000) begin
      errors++; $display("FAIL prio_gap got=%b/%b/%b exp=0/0/1000", in_service, squash, pending); end
    step();
    drive('0, 0, '0, 0, 0, 0);
    checks++;
    if (squash !== 1'b1 || irq_id !== 3'd3 || irq_pc_addr !== 8'hFC) begin
      errors++; $display("FAIL prio_second got=%b/%0d/%h exp=1/3/fc", squash, irq_id, irq_pc_addr); end
    step();
    finish_service();
  endtask

  task automatic test_mask_gie();
    drive('0, 1, 4'b1110, 0, 0, 0); step();
    drive(4'b0001, 0, '0, 0, 0, 0); step();
    for (int k = 0; k < 3; k++) begin
      drive('0, 0, '0, 0, 0, 0);
      checks++;
      if (pending[0] !== 1'b1 || squash !== 1'b0) begin
        errors++; $display("FAIL masked_blocked got=%b/%b exp=1/0", pending[0], squash); end
      step();
    end
    drive('0, 1, 4'b1111, 0, 0, 0); step();
    drive('0, 0, '0, 0, 0, 0);
    checks++;
    if (squash !== 1'b0) begin errors++; $display("FAIL unmask_decide got=%b exp=0", squash); end
    step();
    drive('0, 0, '0, 0, 0, 0);
    checks++;
    if (squash !== 1'b1 || irq_id !== 3'd0 || irq_pc_addr !== 8'hF0) begin
      errors++; $display("FAIL unmask_take got=%b/%0d/%h exp=1/0/f0", squash, irq_id, irq_pc_addr); end
    step();
    finish_service();
    drive('0, 0, '0, 0, 1, 0); step();
    drive(4'b0001, 0, '0, 0, 0, 0); step();
    for (int k = 0; k < 3; k++) begin
      drive('0, 0, '0, 0, 0, 0);
      checks++;
      if (in_service !== 1'b0) begin errors++; $display("FAIL gie_off got=%b exp=0", in_service); end
      step();
    end
    drive('0, 0, '0, 1, 1, 0); step();
    for (int k = 0; k < 3; k++) begin
      drive('0, 0, '0, 0, 0, 0);
      checks++;
      if (in_service !== 1'b0) begin errors++; $display("FAIL ei_di_both got=%b exp=0", in_service); end
      step();
    end
    drive('0, 0, '0, 1, 0, 0); step();
    drive('0, 0, '0, 0, 0, 0); step();
    drive('0, 0, '0, 0, 0, 0);
    checks++;
    if (squash !== 1'b1 || irq_id !== 3'd0) begin
      errors++; $display("FAIL ei_take got=%b/%0d exp=1/0", squash, irq_id); end
    step();
    finish_service();
  endtask

  task automatic test_no_nest();
    drive(4'b0100, 0, '0, 0, 0, 0); step();
    drive('0, 0, '0, 0, 0, 0); step();
    drive('0, 0, '0, 0, 0, 0); step();
    drive(4'b0001, 0, '0, 0, 0, 0); step();
    for (int k = 0; k < 3; k++) begin
      drive('0, 0, '0, 0, 0, 0);
      checks++;
      if (in_service !== 1'b1 || squash !== 1'b0 || irq_id !== 3'd2 || pending[0] !== 1'b1) begin
        errors++; $display("FAIL no_nest got=%b/%b/%0d/%b exp=1/0/2/1", in_service, squash, irq_id, pending[0]); end
      step();
    end
    drive('0, 0, '0, 0, 0, 1); step();
    drive('0, 0, '0, 0, 0, 0); step();
    drive('0, 0, '0, 0, 0, 0);
    checks++;
    if (squash !== 1'b1 || irq_id !== 3'd0) begin
      errors++; $display("FAIL nest_after got=%b/%0d exp=1/0", squash, irq_id); end
    step();
    finish_service();
  endtask

  task automatic test_edge();
    int takes = 0;
    for (int k = 0; k < 16; k++) begin
      drive((k < 10) ? 4'b0010 : 4'b0000, 0, '0, 0, 0, m_busy && !m_take);
      if (squash === 1'b1) takes++;
      step();
    end
    checks++;
    if (takes !== 1) begin errors++; $display("FAIL level_once got=%0d exp=1", takes); end
    drive('0, 0, '0, 0, 0, 1);
    checks++;
    if (irq_pc_ld !== 1'b0) begin errors++; $display("FAIL stray_iret got=%b exp=0", irq_pc_ld); end
    step();
  endtask

  task automatic test_reset_mid();
    drive(4'b1000, 0, '0, 0, 0, 0); step();
    drive('0, 0, '0, 0, 0, 0); step();
    drive('0, 0, '0, 0, 0, 0); step();
    drive(4'b0010, 0, '0, 0, 0, 0); step();
    drive('0, 0, '0, 0, 0, 1);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (in_service !== 1'b0 || pending !== 4'b0000 || irq_pc_ld !== 1'b0) begin
      errors++; $display("FAIL async_reset got=%b/%b/%b exp=0/0000/0", in_service, pending, irq_pc_ld); end
    step();
    rst = 1'b0;
    drive('0, 0, '0, 0, 0, 0);
    checks++;
    if (in_service !== 1'b0) begin errors++; $display("FAIL post_reset_idle got=%b exp=0", in_service); end
    step();
    drive('0, 0, '0, 0, 0, 1);
    checks++;
    if (irq_pc_ld !== 1'b0) begin errors++; $display("FAIL post_reset_iret got=%b exp=0", irq_pc_ld); end
    step();
  endtask

  task automatic test_random();
    for (int k = 0; k < 500; k++) begin
      pc_cur = 8'($urandom);
      drive(4'($urandom & $urandom & $urandom), ($urandom_range(0, 9) == 0), 4'($urandom | $urandom),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 11) == 0), ($urandom_range(0, 2) == 0));
      checks++;
      if (obs !== exp_vec()) begin
        errors++; $display("FAIL random_cycle%0d got=%h exp=%h", k, obs, exp_vec()); end
      step();
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_mask_gie();
    test_no_nest();
    test_edge();
    test_reset_mid();
    drive('0, 1, 4'hF, 1, 0, 0); step();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
